audio_level_meter: RTL and testbench

// - Downstream of the PDM mic decimator. Consumes the signed PCM sample stream (one sample per strobe).
// - Produces a per-window mean absolute level and a peak envelope with exponential decay.
// - Results leave on a valid/ready port that drives the audio-reactive LED pattern logic.

---
 rtl/audio_level_meter.sv | 160 ++++++++++++++++
 tb/tb_audio_level_meter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/audio_level_meter.sv
// Windowed mean-|x| level and decaying peak envelope for the PCM stream, on a valid/ready result port.
// Optional DC-blocking front end enabled by AUDIO_LEVEL_DC_BLOCK_EN (off by default).
module audio_level_meter #(
    parameter int SAMPLE_DEPTH = 16,
    parameter int WINDOW_LOG2  = 8,
    parameter int DECAY_SHIFT  = 4,
    parameter int DC_SHIFT     = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLE_DEPTH-1:0]   sample_in,
    input  logic                      sample_strobe,
    output logic [SAMPLE_DEPTH-2:0]   avg_level,
    output logic [SAMPLE_DEPTH-2:0]   envelope,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      overrun,
    input  logic                      clear_overrun
);
    localparam int LW = SAMPLE_DEPTH - 1;
    localparam int AW = LW + WINDOW_LOG2;
    localparam logic [SAMPLE_DEPTH-1:0] SMIN = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
    localparam logic [SAMPLE_DEPTH-1:0] SMAX = {1'b0, {(SAMPLE_DEPTH-1){1'b1}}};

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    logic [SAMPLE_DEPTH-1:0] x_corr;

`ifdef AUDIO_LEVEL_DC_BLOCK_EN
    localparam int DW = SAMPLE_DEPTH + DC_SHIFT;
    logic signed [DW-1:0]         dc;
    logic signed [DW:0]           x_wide;
    logic signed [DW:0]           dc_wide;
    logic signed [DW:0]           dc_err;
    logic signed [DW:0]           dc_step;
    logic [SAMPLE_DEPTH-1:0]      dc_est;
    logic [SAMPLE_DEPTH:0]        x_diff;

    // Correction uses the estimate from before this sample's update, so no extra latency.
    always_comb begin
        x_wide  = {{(DC_SHIFT+1){sample_in[SAMPLE_DEPTH-1]}}, sample_in};
        dc_wide = {dc[DW-1], dc};
        dc_err  = (x_wide <<< DC_SHIFT) - dc_wide;
        dc_step = dc_err >>> DC_SHIFT;
        dc_est  = dc[DW-1:DC_SHIFT];
        x_diff  = {sample_in[SAMPLE_DEPTH-1], sample_in} - {dc_est[SAMPLE_DEPTH-1], dc_est};
        if (x_diff[SAMPLE_DEPTH] != x_diff[SAMPLE_DEPTH-1])
            x_corr = x_diff[SAMPLE_DEPTH] ? SMIN : SMAX;
        else
            x_corr = x_diff[SAMPLE_DEPTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            dc <= '0;
        else if (sample_strobe)
            dc <= dc + dc_step[DW-1:0];
    end
`else
    assign x_corr = sample_in;
`endif

    logic [SAMPLE_DEPTH-1:0] x_neg;
    logic [LW-1:0]           a_next;
    logic [LW-1:0]           a_reg;
    logic                    a_valid;

    // The most negative code has no positive twin and saturates to full scale.
    always_comb begin
        x_neg = -x_corr;
        if (x_corr == SMIN)
            a_next = SMAX[LW-1:0];
        else if (x_corr[SAMPLE_DEPTH-1])
            a_next = x_neg[LW-1:0];
        else
            a_next = x_corr[LW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            a_valid <= 1'b0;
        end else begin
            a_valid <= sample_strobe;
            if (sample_strobe)
                a_reg <= a_next;
        end
    end

    logic [AW-1:0]          acc;
    logic [AW-1:0]          acc_sum;
    logic [AW-1:0]          acc_avg;
    logic [LW-1:0]          wpeak;
    logic [LW-1:0]          wpeak_max;
    logic [LW-1:0]          env_next;
    logic [WINDOW_LOG2-1:0] cnt;
    logic                   win_end;

    always_comb begin
        acc_sum   = acc + {{WINDOW_LOG2{1'b0}}, a_reg};
        acc_avg   = acc_sum >> WINDOW_LOG2;
        wpeak_max = (a_reg > wpeak) ? a_reg : wpeak;
        env_next  = envelope - (envelope >> DECAY_SHIFT);
        win_end   = a_valid && (cnt == {WINDOW_LOG2{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            wpeak     <= '0;
            cnt       <= '0;
            avg_level <= '0;
            envelope  <= '0;
        end else if (a_valid) begin
            cnt <= cnt + 1'b1;
            if (win_end) begin
                acc       <= '0;
                wpeak     <= '0;
                avg_level <= acc_avg[LW-1:0];
                envelope  <= (wpeak_max > env_next) ? wpeak_max : env_next;
            end else begin
                acc   <= acc_sum;
                wpeak <= wpeak_max;
            end
        end
    end

    state_t state_q, state_d;
    logic   overrun_set;

    always_comb begin
        state_d     = state_q;
        overrun_set = 1'b0;
        case (state_q)
            EMPTY: if (win_end) state_d = FULL;
            FULL: begin
                if (win_end)
                    overrun_set = !out_ready;
                else if (out_ready)
                    state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (overrun_set)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;
        end
    end

    assign out_valid = (state_q == FULL);
endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench for audio_level_meter with WINDOW_LOG2=2, DECAY_SHIFT=4; strobe every 4 clk.
module tb_audio_level_meter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_strobe;
    logic [14:0] avg_level;
    logic [14:0] envelope;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        clear_overrun;

    int pass_cnt = 0;
    int total    = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    audio_level_meter #(
        .SAMPLE_DEPTH(16), .WINDOW_LOG2(2), .DECAY_SHIFT(4), .DC_SHIFT(10)
    ) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_strobe(sample_strobe),
        .avg_level(avg_level), .envelope(envelope), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .clear_overrun(clear_overrun)
    );

    always @(negedge clk) if (out_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] x);
        @(negedge clk);
        sample_in     = x;
        sample_strobe = 1'b1;
        @(negedge clk) sample_strobe = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Last sample of a window: checks valid one cycle after the strobe, result two cycles after.
    task automatic send_last(input string tag, input logic [15:0] x, input logic pre_v,
                             input logic [14:0] ea, input logic [14:0] ee, input logic post_v);
        @(negedge clk);
        sample_in     = x;
        sample_strobe = 1'b1;
        @(negedge clk) sample_strobe = 1'b0;
        check({tag, "_pre_valid"}, 32'(out_valid), 32'(pre_v));
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_avg"}, 32'(avg_level), 32'(ea));
        check({tag, "_env"}, 32'(envelope), 32'(ee));
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(out_valid), 32'(post_v));
    endtask

    initial begin
        rst = 1'b1; sample_in = '0; sample_strobe = 1'b0;
        out_ready = 1'b1; clear_overrun = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_avg", 32'(avg_level), 32'd0);
        check("rst_env", 32'(envelope), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        repeat (3) send(16'd100);
        send_last("w100", 16'd100, 1'b0, 15'd100, 15'd100, 1'b0);

        repeat (3) send(16'h8000);
        send_last("wsat", 16'h8000, 1'b0, 15'd32767, 15'd32767, 1'b0);

        do_reset();
        repeat (3) send(16'd0);
        send_last("w400", 16'd400, 1'b0, 15'd100, 15'd400, 1'b0);
        repeat (3) send(16'd0);
        send_last("wdecay", 16'd0, 1'b0, 15'd0, 15'd375, 1'b0);

        do_reset();
        out_ready = 1'b0;
        repeat (3) send(16'd8);
        send_last("w8", 16'd8, 1'b0, 15'd8, 15'd8, 1'b1);
        check("w8_overrun", 32'(overrun), 32'd0);
        repeat (3) send(16'd16);
        send_last("w16", 16'd16, 1'b1, 15'd16, 15'd16, 1'b1);
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (3) @(negedge clk);
        check("hold_avg", 32'(avg_level), 32'd16);
        check("hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("accept_valid", 32'(out_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clk) clear_overrun = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);

        repeat (2) send(16'd500);
        do_reset();
        pulses = 0;
        repeat (3) send(16'd20);
        check("rst_partial_nopulse", 32'(pulses), 32'd0);
        send_last("w20", 16'd20, 1'b0, 15'd20, 15'd20, 1'b0);
        repeat (4) @(negedge clk);
        check("w20_pulses", 32'(pulses), 32'd1);

`ifdef AUDIO_LEVEL_DC_BLOCK_EN
        do_reset();
        for (int i = 0; i < 8192; i++) send(16'd1000);
        check("dc_block_avg_low", 32'(avg_level < 15'd10), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
